mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Initiator/writer for the data memory port (addr, ce, data_in, data_out).
//  - Takes a byte stream over a valid/ready handshake.
//  - Writes each item to consecutive addresses starting at a base address.
//  - Reads the region back and checks it against a running checksum.
//  - Sits beside the core. It owns the memory port while busy; cpu_hold stalls the core.
// PARAMETERS
//  WIDTH    8   data word width, equal to the memory WIDTH
//  A_WIDTH  10  address width, equal to the memory A_WIDTH
// PORTS
//  clk        in   1          clock; all state changes on posedge
//  rst        in   1          reset: synchronous, active-high
//  start      in   1          one-cycle pulse, accepted only in IDLE
//  base       in   A_WIDTH    first address, sampled with start
//  count      in   A_WIDTH+1  number of words, sampled with start; 0..2**A_WIDTH
//  in_valid   in   1          stream word valid
//  in_data    in   WIDTH      stream word
//  in_ready   out  1          loader accepts in_data this cycle
//  mem_addr   out  A_WIDTH    memory address (addr_id side of the memory mux)
//  mem_ce     out  1          memory write enable
//  mem_wdata  out  WIDTH      memory write data
//  mem_rdata  in   WIDTH      memory data_out (combinational read of mem_addr)
//  cpu_hold   out  1          high while not IDLE; core stalls, mux selects loader
//  done       out  1          one-cycle pulse: region written and verified OK
//  error      out  1          one-cycle pulse: readback checksum mismatch
// BEHAVIOUR
//  Reset values: state=IDLE. All outputs 0. Internal addr, remaining, sum_w, sum_r = 0.
//  States: IDLE -> LOAD -> VERIFY -> IDLE. Pulses on leaving VERIFY:
//   - done when sum_r == sum_w
//   - error otherwise
//  IDLE:
//   - On start, latch base into ptr and count into remaining.
//   - Clear sum_w and sum_r.
//   - If count==0: next state IDLE and done pulses the next cycle (no memory access).
//   - Otherwise go to LOAD.
//   - start outside IDLE is ignored.
//  LOAD:
//   - in_ready = 1.
//   - Handshake: a transfer occurs when in_valid && in_ready, and only then.
//   - On transfer, combinationally: mem_ce=1, mem_addr=ptr, mem_wdata=in_data.
//     The memory captures the word at that posedge.
//   - Same edge: ptr<=ptr+1; remaining<=remaining-1; sum_w<=sum_w+in_data.
//   - At the last transfer (remaining==1): ptr<=base, remaining<=count, go to VERIFY.
//   - No transfer: mem_ce=0 and state holds. Stalls of any length are legal.
//  VERIFY:
//   - in_ready=0, mem_ce=0, mem_addr=ptr.
//   - Each cycle: sum_r<=sum_r+mem_rdata, ptr<=ptr+1, remaining<=remaining-1.
//   - Exactly count cycles, then return to IDLE and pulse done or error.
//  Outside LOAD/VERIFY: mem_addr = ptr, mem_ce = 0.
//  Arithmetic:
//   - ptr wraps modulo 2**A_WIDTH (base=2**A_WIDTH-1, count=2 writes top, then 0).
//   - Sums are modulo 2**WIDTH.
//   - count=2**A_WIDTH covers the whole memory once.
//  Latency: start to first possible write is 1 cycle. Total = 1 + load cycles + count + 1.
//  cpu_hold is registered from the state: high in LOAD and VERIFY, low in IDLE.
//  done/error are registered and mutually exclusive.
//  rst mid-operation:
//   - Next edge: IDLE, outputs 0, no done/error.
//   - Words already written stay in memory.
// STRUCTURE
//  Shared package/enums.svh:
//   - loader_state_t {LD_IDLE, LD_LOAD, LD_VERIFY}, 2-bit enum.
//   - A note that mem_loader drives the addr_id path (a_source = SRC_MEM_ADDR while cpu_hold).
//  Single module. An optional sub-module ld_sum (WIDTH-bit accumulator with clear/enable)
//  is instantiated twice, for sum_w and sum_r.
// TESTING (bench instantiates mem with WIDTH=8, A_WIDTH=4)
//  1. base=3, count=4, stream 11,22,33,44 back-to-back:
//     mem[3..6]=11,22,33,44; done once, 10 cycles after start; error never.
//  2. Same as 1 with in_valid gaps (valid every 3rd cycle):
//     identical memory contents; cpu_hold high throughout; in_ready=1 only in LOAD.
//  3. base=14, count=4, data 1,2,3,4:
//     mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4 (wrap-around); done.
//  4. count=0:
//     no mem_ce, cpu_hold stays 0, done pulses one cycle after start.
//  5. Bench forces mem[5] to FF during VERIFY (base=4, count=3, data 1,2,3):
//     error pulses, done stays 0.
//  6. rst asserted after 2 of 4 words:
//     next cycle IDLE, cpu_hold=0; a later start works normally; second start during LOAD ignored.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// ============================================================================
// Module      : mem_loader_pkg
// Description : Shared types for the memory loader. mem_loader drives the
//               addr_id path of the memory mux (a_source = SRC_MEM_ADDR while
//               cpu_hold is high).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_loader_pkg;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_LOAD   = 2'd1,
        LD_VERIFY = 2'd2
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_loader_ld_sum.sv
// ============================================================================
// Module      : ld_sum
// Description : WIDTH-bit wrapping accumulator with synchronous clear/enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_sum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] add,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= r_sum + add;
        end
    end

    assign sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// Module      : mem_loader
// Description : Streams words into memory from a base address, then reads the
//               region back and compares checksums. Holds the core while busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int A_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base,
    input  logic [A_WIDTH:0]   count,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_ce,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    loader_state_t      r_state;
    logic [A_WIDTH-1:0] r_ptr;
    logic [A_WIDTH-1:0] r_base;
    logic [A_WIDTH:0]   r_remaining;
    logic [A_WIDTH:0]   r_count;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;

    logic               w_xfer;
    logic               w_last;
    logic               w_clr;
    logic               w_verify;
    logic [WIDTH-1:0]   w_sum_w;
    logic [WIDTH-1:0]   w_sum_r;
    logic [WIDTH-1:0]   w_sum_r_next;

    assign in_ready     = (r_state == LD_LOAD);
    assign w_xfer       = in_ready && in_valid;
    assign w_verify     = (r_state == LD_VERIFY);
    assign w_last       = (r_remaining == (A_WIDTH+1)'(1));
    assign w_clr        = (r_state == LD_IDLE) && start;
    // Final verify decision must include the word being read this cycle.
    assign w_sum_r_next = w_sum_r + mem_rdata;

    assign mem_addr  = r_ptr;
    assign mem_ce    = w_xfer;
    assign mem_wdata = in_data;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

    ld_sum #(.WIDTH(WIDTH)) u_sum_w (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_xfer),
        .add (in_data),
        .sum (w_sum_w)
    );

    ld_sum #(.WIDTH(WIDTH)) u_sum_r (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_verify),
        .add (mem_rdata),
        .sum (w_sum_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LD_IDLE;
            r_ptr       <= '0;
            r_base      <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                LD_IDLE: begin
                    if (start) begin
                        r_ptr       <= base;
                        r_base      <= base;
                        r_remaining <= count;
                        r_count     <= count;
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= LD_LOAD;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                end
                LD_LOAD: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_ptr       <= r_base;
                            r_remaining <= r_count;
                            r_state     <= LD_VERIFY;
                        end else begin
                            r_ptr       <= r_ptr + A_WIDTH'(1);
                            r_remaining <= r_remaining - (A_WIDTH+1)'(1);
                        end
                    end
                end
                LD_VERIFY: begin
                    r_ptr       <= r_ptr + A_WIDTH'(1);
                    r_remaining <= r_remaining - (A_WIDTH+1)'(1);
                    if (w_last) begin
                        r_state    <= LD_IDLE;
                        r_cpu_hold <= 1'b0;
                        if (w_sum_r_next == w_sum_w) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= LD_IDLE;
                    r_cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// Module      : tb_mem_loader
// Description : Directed bench for mem_loader with a behavioural memory and a
//               write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_loader;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_ce;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    logic [W-1:0]  mem [0:15];
    logic          corrupt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int hold_bad = 0;
    bit chk_hold = 1'b0;
    int d0;
    int e0;
    logic [AW+W-1:0] exp_q [$];

    mem_loader #(.WIDTH(W), .A_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_ce    (mem_ce),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (mem_ce === 1'b1) mem[mem_addr] <= mem_wdata;
    end

    // Corruption models a location changing underneath the verify pass.
    assign mem_rdata = (corrupt && mem_addr == 4'd5) ? 8'hFF : mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_ce === 1'b1) begin
            logic [AW+W-1:0] e;
            check("write_queued", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_addr_data", 32'({mem_addr, mem_wdata}), 32'(e));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (error === 1'b1) err_cnt++;
        if (chk_hold && cpu_hold !== 1'b1) hold_bad++;
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
        start = 1'b1;
        base  = b;
        count = c;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] d, input int gap, input logic [AW-1:0] a);
        bit ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_data  = d;
        in_valid = 1'b1;
        exp_q.push_back({a, d});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        in_valid = 1'b0;
        check("handshake_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("end_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] d1 [4];
        d1 = '{8'd11, 8'd22, 8'd33, 8'd44};
        rst = 1'b1; start = 1'b0; base = '0; count = '0;
        in_valid = 1'b0; in_data = '0; corrupt = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_ce",   32'(mem_ce),   32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // 1: back-to-back stream
        d0 = done_cnt; e0 = err_cnt;
        do_start(4'd3, 5'd4);
        for (int i = 0; i < 4; i++) send_word(d1[i], 0, 4'(3 + i));
        wait_end();
        check("t1_latency", 32'(done_cyc - start_cyc + 2), 32'd10);
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_error", 32'(err_cnt - e0), 32'd0);
        for (int i = 0; i < 4; i++) check("t1_mem", 32'(mem[3 + i]), 32'(d1[i]));

        // 2: valid every third cycle
        d0 = done_cnt; e0 = err_cnt;
        do_start(4'd3, 5'd4);
        chk_hold = 1'b1;
        for (int i = 0; i < 4; i++) send_word(d1[i], 2, 4'(3 + i));
        @(negedge clk);
        check("t2_ready_verify", 32'(in_ready), 32'd0);
        check("t2_hold_verify", 32'(cpu_hold), 32'd1);
        chk_hold = 1'b0;
        wait_end();
        check("t2_hold_load", 32'(hold_bad), 32'd0);
        check("t2_ready_idle", 32'(in_ready), 32'd0);
        check("t2_done", 32'(done_cnt - d0), 32'd1);
        check("t2_error", 32'(err_cnt - e0), 32'd0);
        for (int i = 0; i < 4; i++) check("t2_mem", 32'(mem[3 + i]), 32'(d1[i]));

        // 3: address wrap
        d0 = done_cnt;
        do_start(4'd14, 5'd4);
        for (int i = 0; i < 4; i++) send_word(8'(i + 1), 0, 4'(14 + i));
        wait_end();
        check("t3_mem14", 32'(mem[14]), 32'd1);
        check("t3_mem15", 32'(mem[15]), 32'd2);
        check("t3_mem0",  32'(mem[0]),  32'd3);
        check("t3_mem1",  32'(mem[1]),  32'd4);
        check("t3_done", 32'(done_cnt - d0), 32'd1);

        // 4: empty transfer
        d0 = done_cnt;
        do_start(4'd7, 5'd0);
        @(negedge clk);
        check("t4_done_pulse", 32'(done), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd0);
        check("t4_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t4_done_clear", 32'(done), 32'd0);
        check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
        @(posedge clk); #1;

        // 5: corrupted readback
        d0 = done_cnt; e0 = err_cnt;
        do_start(4'd4, 5'd3);
        for (int i = 0; i < 3; i++) send_word(8'(i + 1), 0, 4'(4 + i));
        corrupt = 1'b1;
        wait_end();
        corrupt = 1'b0;
        check("t5_error", 32'(err_cnt - e0), 32'd1);
        check("t5_done", 32'(done_cnt - d0), 32'd0);

        // 6: reset mid-load, then restart with an ignored second start
        d0 = done_cnt; e0 = err_cnt;
        do_start(4'd0, 5'd4);
        send_word(8'h5A, 0, 4'd0);
        send_word(8'hA5, 0, 4'd1);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_error", 32'(error), 32'd0);
        check("t6_mem0", 32'(mem[0]), 32'h5A);
        check("t6_mem1", 32'(mem[1]), 32'hA5);
        @(posedge clk); #1;
        do_start(4'd8, 5'd2);
        send_word(8'd5, 0, 4'd8);
        start = 1'b1; base = 4'd12; count = 5'd0;
        send_word(8'd6, 0, 4'd9);
        start = 1'b0;
        wait_end();
        repeat (3) @(posedge clk);
        #1;
        check("t6_restart_done", 32'(done_cnt - d0), 32'd1);
        check("t6_restart_error", 32'(err_cnt - e0), 32'd0);
        check("t6_mem8", 32'(mem[8]), 32'd5);
        check("t6_mem9", 32'(mem[9]), 32'd6);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
